// File: rtl/tt_sweep_ctrl.sv
// Sweeps {a,b,c,d} through vectors 0..15 and captures the external function's truth table.
// Latency: done pulses 16*(DWELL+1)+1 cycles after start is accepted; each vector takes DWELL+1 cycles.
// Backpressure: none; start is honoured only in IDLE, abort cancels a sweep and keeps the partial result.
module tt_sweep_ctrl #(
  parameter int DWELL = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        f_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt,
  output logic [4:0]  ones_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Final settle count before moving to SAMPLE (DWELL is 1..15, so it fits in 4 bits).
  localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  timer_q, timer_d;
  logic [15:0] tt_q, tt_d;
  logic [4:0]  ones_q, ones_d;

  // State and datapath registers; reset clears every captured result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      timer_q <= 4'd0;
      tt_q    <= 16'h0000;
      ones_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      tt_q    <= tt_d;
      ones_q  <= ones_d;
    end
  end

  // Next-state logic: dwell in DRIVE, capture in SAMPLE, one-cycle DONE pulse.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    tt_d    = tt_q;
    ones_d  = ones_q;
    case (state_q)
      IDLE: begin
        // abort wins over start so a stuck abort line cannot launch a sweep.
        if (start && !abort) begin
          state_d = DRIVE;
          idx_d   = 4'd0;
          timer_d = 4'd0;
          tt_d    = 16'h0000;
          ones_d  = 5'd0;
        end
      end
      DRIVE: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 4'd1;
          if (timer_q == DWELL_LAST) begin
            state_d = SAMPLE;
          end
        end
      end
      SAMPLE: begin
        // An abort here drops the sample for the current vector.
        if (abort) begin
          state_d = IDLE;
        end else begin
          tt_d[idx_q] = f_in;
          ones_d      = ones_q + {4'd0, f_in};
          if (idx_q == 4'd15) begin
            // idx stays at 15 so IDLE keeps showing the last vector applied.
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            timer_d = 4'd0;
            state_d = DRIVE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign {a, b, c, d} = idx_q;
  assign busy         = (state_q == DRIVE) || (state_q == SAMPLE);
  assign done         = (state_q == DONE);
  assign tt           = tt_q;
  assign ones_cnt     = ones_q;

endmodule

// File: doc/tt_sweep_ctrl.md
TT_SWEEP_CTRL -- requirements
Module: tt_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter DWELL, default 2, giving the settle cycles per vector before sampling; legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: sweep request, sampled in IDLE only.
REQ-005 The block SHALL have port abort, input, 1 bit: cancels a running sweep.
REQ-006 The block SHALL have port f_in, input, 1 bit: output of the 4-input function under sweep.
REQ-007 The block SHALL have ports a, b, c, d, outputs, 1 bit each: the drive to the function inputs.
REQ-008 The block SHALL have port busy, output, 1 bit: high in DRIVE or SAMPLE.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 The block SHALL have port tt, output, 16 bits: captured truth table, where bit i is f for vector i.
REQ-011 The block SHALL have port ones_cnt, output, 5 bits: number of vectors with f=1, range 0..16.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, DRIVE, SAMPLE, DONE.
REQ-013 The block SHALL hold a 4-bit vector index idx and drive {a,b,c,d} = idx[3:0], so a is the MSB and d the LSB; vectors SHALL be applied in ascending order 0..15.
REQ-014 IDLE with start=1 and abort=0: next cycle DRIVE, with idx=0, dwell timer=0, tt=0 and ones_cnt=0.
REQ-015 IDLE with start=0, or with abort=1: remain in IDLE with tt and ones_cnt unchanged.
REQ-016 DRIVE: the timer SHALL increment each cycle; when the timer equals DWELL-1, the next state SHALL be SAMPLE.
REQ-017 SAMPLE: the block SHALL set tt[idx] to f_in and add f_in to ones_cnt.
REQ-018 SAMPLE with idx<15: the block SHALL increment idx, clear the timer and return to DRIVE.
REQ-019 SAMPLE with idx=15: the next state SHALL be DONE, with idx held at 15.
REQ-020 DONE: done SHALL be 1 for exactly this one cycle, and the next state SHALL be IDLE.
REQ-021 Each vector SHALL occupy exactly DWELL+1 cycles.
REQ-022 done SHALL assert exactly 16*(DWELL+1)+1 cycles after the cycle in which start was accepted; with DWELL=2 this is 49 cycles.
REQ-023 start SHALL be ignored while busy=1 or in DONE; no restart and no result clear.
REQ-024 abort=1 in DRIVE or SAMPLE SHALL move the FSM to IDLE next cycle and suppress any sample in that cycle.
REQ-025 After an abort, done SHALL NOT pulse, and tt and ones_cnt SHALL retain the bits captured so far.
REQ-026 abort in DONE SHALL be ignored; done still pulses.
REQ-027 In IDLE, {a,b,c,d} SHALL hold the last applied idx.
REQ-028 After DONE, tt and ones_cnt SHALL stay stable until the next accepted start.
REQ-029 ones_cnt SHALL be 5 bits wide so it never wraps; 16 ones reads as 5'd16.
REQ-030 idx SHALL never wrap from 15 to 0 within a sweep.

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE with idx=0, timer=0, a=b=c=d=0, busy=0, done=0, tt=16'h0000 and ones_cnt=0.
REQ-032 rst SHALL take priority over start and abort.
REQ-033 rst asserted mid-sweep SHALL discard the partial results, and no done pulse SHALL follow.
REQ-034 After rst is released, the block SHALL accept start on the first IDLE cycle.

Verification
REQ-035 Parity model (f_in=a^b^c^d), DWELL=2, start pulsed once -> done pulse 49 cycles later, tt=16'h6996, ones_cnt=8, busy low afterwards.
REQ-036 f_in tied to 1 -> tt=16'hFFFF, ones_cnt=5'd16; f_in tied to 0 -> tt=16'h0000, ones_cnt=0.
REQ-037 start re-pulsed at cycle 10 of a sweep -> no effect: done still at cycle 49 and tt unchanged from the parity result.
REQ-038 Parity model, abort asserted during the DRIVE of vector 5 -> IDLE next cycle, no done, tt=16'h0016 (bits 1, 2 and 4 set), ones_cnt=3.
REQ-039 rst asserted during vector 9, then released, then start -> all outputs zero on the cycle after rst; the fresh sweep completes with tt=16'h6996.
REQ-040 start and abort high together in IDLE -> stays in IDLE, busy=0, tt unchanged.
